// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: primary writeback vs. FIFO-buffered long-latency results.
// Optional RAW/WAW scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p_we,
  input  logic [AW-1:0]            p_addr,
  input  logic [DW-1:0]            p_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [AW-1:0]            s_addr,
  input  logic [DW-1:0]            s_data,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  input  logic [AW-1:0]            rd_addrA,
  input  logic [AW-1:0]            rd_addrB,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_addrD,
  output logic [DW-1:0]            rf_dataD,
  output logic                     core_stall,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wait_cnt;
  logic          empty, full, force_grant, hazard, push, pop;

  assign fifo_cnt = cnt;

  always_comb begin
    empty       = (cnt == '0);
    full        = (cnt == CW'(DEPTH));
    force_grant = (wait_cnt == WW'(MAX_WAIT)) && !empty;
    s_ready     = rst_n && !full;
    push        = s_valid && s_ready;
    rf_we       = 1'b0;
    rf_addrD    = p_addr;
    rf_dataD    = p_data;
    core_stall  = 1'b0;
    pop         = 1'b0;
    if (rst_n) begin
      if (force_grant || hazard) begin
        core_stall = 1'b1;
        pop        = !empty;
      end else if (p_we) begin
        rf_we = 1'b1;
      end else begin
        pop = !empty;
      end
      if (pop) begin
        rf_we    = 1'b1;
        rf_addrD = q_addr[rd_ptr];
        rf_dataD = q_data[rd_ptr];
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= s_addr;
      q_data[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (pop || empty)
        wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NREG = 1 << AW;
  logic [NREG-1:0] busy, busy_nxt;

  assign hazard = (p_we && busy[p_addr]) || busy[rd_addrA] || busy[rd_addrB];

  // Clear before set so a same-cycle issue to the popped register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[q_addr[rd_ptr]] = 1'b0;
    if (iss_valid && !core_stall && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_addr, rd_addrA, rd_addrB};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 4, MAX_WAIT = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          p_we = 0, s_valid = 0, iss_valid = 0;
  logic [AW-1:0] p_addr = 0, s_addr = 0, iss_addr = 0, rd_addrA = 0, rd_addrB = 0;
  logic [DW-1:0] p_data = 0, s_data = 0;
  logic          s_ready, rf_we, core_stall;
  logic [AW-1:0] rf_addrD;
  logic [DW-1:0] rf_dataD;
  logic [2:0]    fifo_cnt;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .rf_we(rf_we), .rf_addrD(rf_addrD), .rf_dataD(rf_dataD), .core_stall(core_stall),
    .fifo_cnt(fifo_cnt));

  // Reference model: pending results as a queue, scoreboard as a bit per register.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; bit stall; bit sready; bit pop; bit push; } exp_t;

  ent_t m_q[$];
  int   m_wait = 0;
  bit   m_busy[32];
  exp_t m_e;
  int   m_sz;

  function automatic exp_t model_eval();
    exp_t e;
    bit   hz, frc;
    e = '{we: 0, addr: '0, data: '0, stall: 0, sready: 0, pop: 0, push: 0};
    if (!rst_n) return e;
    hz = 0;
`ifdef RF_WB_SCOREBOARD_EN
    hz = (p_we && m_busy[p_addr]) || m_busy[rd_addrA] || m_busy[rd_addrB];
`endif
    frc      = (m_wait >= MAX_WAIT) && m_q.size() != 0;
    e.sready = m_q.size() < DEPTH;
    e.push   = s_valid && e.sready;
    if (frc || hz) begin
      e.stall = 1;
      e.pop   = m_q.size() != 0;
    end else if (p_we) begin
      e.we = 1; e.addr = p_addr; e.data = p_data;
    end else begin
      e.pop = m_q.size() != 0;
    end
    if (e.pop) begin
      e.we = 1; e.addr = m_q[0].a; e.data = m_q[0].d;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_wait = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      m_e  = model_eval();
      m_sz = m_q.size();
      if (m_e.pop) begin
        m_busy[m_q[0].a] = 0;
        void'(m_q.pop_front());
      end
      if (m_e.push) m_q.push_back('{a: s_addr, d: s_data});
      if (m_e.pop || m_sz == 0) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
`ifdef RF_WB_SCOREBOARD_EN
      if (iss_valid && !m_e.stall && iss_addr != 0) m_busy[iss_addr] = 1;
`endif
    end
  end

  task automatic idle_inputs();
    p_we = 0; s_valid = 0; iss_valid = 0;
    p_addr = 0; s_addr = 0; iss_addr = 0; rd_addrA = 0; rd_addrB = 0;
    p_data = 0; s_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; p_we = 1; p_addr = 5; s_valid = 1; s_addr = 6;
    #1;
    n_vec++; if (rf_we !== 1'b0)      begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_vec++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", core_stall); end
    n_vec++; if (s_ready !== 1'b0)    begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_vec++; if (fifo_cnt !== 3'd0)   begin n_err++; $display("FAIL reset_fifo_cnt: got %0d want 0", fifo_cnt); end
    do_reset();
  endtask

  task automatic test_primary();
    @(negedge clk);
    p_we = 1; p_addr = 5; p_data = 32'hDEADBEEF;
    #1;
    n_vec++; if (rf_we !== 1'b1)            begin n_err++; $display("FAIL prim_we: got %b want 1", rf_we); end
    n_vec++; if (rf_addrD !== 5'd5)         begin n_err++; $display("FAIL prim_addr: got %0d want 5", rf_addrD); end
    n_vec++; if (rf_dataD !== 32'hDEADBEEF) begin n_err++; $display("FAIL prim_data: got %h want deadbeef", rf_dataD); end
    n_vec++; if (core_stall !== 1'b0)       begin n_err++; $display("FAIL prim_stall: got %b want 0", core_stall); end
  endtask

  task automatic test_drain();
    @(negedge clk);
    p_we = 0; s_valid = 1; s_addr = 7; s_data = 32'h11;
    #1;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL drain_no_passthru: got we=%b want 0", rf_we); end
    @(negedge clk);
    s_valid = 0;
    #1;
    n_vec++; if (fifo_cnt !== 3'd1) begin n_err++; $display("FAIL drain_cnt1: got %0d want 1", fifo_cnt); end
    n_vec++; if (rf_we !== 1'b1 || rf_addrD !== 5'd7 || rf_dataD !== 32'h11)
      begin n_err++; $display("FAIL drain_write: got we=%b a=%0d d=%h want 1/7/11", rf_we, rf_addrD, rf_dataD); end
    @(negedge clk);
    #1;
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL drain_cnt0: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_force();
    logic [DW-1:0] sd, pd;
    int            found;
    do_reset();
    sd = $urandom; pd = $urandom; found = 0;
    @(negedge clk);
    p_we = 1; p_addr = 9; p_data = pd; s_valid = 1; s_addr = 12; s_data = sd;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      s_valid = 0;
      #1;
      if (core_stall) begin found = k; break; end
    end
    n_vec++; if (found != MAX_WAIT + 1) begin n_err++; $display("FAIL force_cycle: got %0d want %0d", found, MAX_WAIT + 1); end
    n_vec++; if (rf_we !== 1'b1 || rf_addrD !== 5'd12 || rf_dataD !== sd)
      begin n_err++; $display("FAIL force_head: got we=%b a=%0d d=%h want 1/12/%h", rf_we, rf_addrD, rf_dataD, sd); end
    @(negedge clk);
    #1;
    n_vec++; if (core_stall !== 1'b0 || rf_addrD !== 5'd9 || rf_dataD !== pd)
      begin n_err++; $display("FAIL force_after: got st=%b a=%0d d=%h want 0/9/%h", core_stall, rf_addrD, rf_dataD, pd); end
  endtask

  task automatic test_full();
    int found;
    do_reset();
    found = 0;
    p_we = 1; p_addr = 2;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      s_valid = 1; s_addr = AW'($urandom_range(1, 31)); s_data = $urandom;
    end
    @(negedge clk);
    s_addr = 20; s_data = 32'hF1F7;
    #1;
    n_vec++; if (fifo_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt: got %0d want 4", fifo_cnt); end
    n_vec++; if (s_ready !== 1'b0)  begin n_err++; $display("FAIL full_ready: got %b want 0", s_ready); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (s_ready) begin found = 1; break; end
    end
    n_vec++; if (found != 1 || fifo_cnt !== 3'd3)
      begin n_err++; $display("FAIL full_release: got found=%0d cnt=%0d want 1/3", found, fifo_cnt); end
    @(negedge clk);
    s_valid = 0;
    #1;
    n_vec++; if (fifo_cnt !== 3'd4) begin n_err++; $display("FAIL full_fifth_push: got %0d want 4", fifo_cnt); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    @(negedge clk);
    iss_valid = 1; iss_addr = 3;
    #1;
    n_vec++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL sb_issue: got stall=%b want 0", core_stall); end
    @(negedge clk);
    iss_valid = 0; rd_addrA = 3;
    #1;
`ifdef RF_WB_SCOREBOARD_EN
    n_vec++; if (core_stall !== 1'b1) begin n_err++; $display("FAIL sb_raw: got stall=%b want 1", core_stall); end
    repeat (3) @(negedge clk);
    s_valid = 1; s_addr = 3; s_data = 32'h33;
    #1;
    n_vec++; if (core_stall !== 1'b1 || rf_we !== 1'b0)
      begin n_err++; $display("FAIL sb_hold: got st=%b we=%b want 1/0", core_stall, rf_we); end
    @(negedge clk);
    s_valid = 0;
    #1;
    n_vec++; if (core_stall !== 1'b1 || rf_we !== 1'b1 || rf_addrD !== 5'd3)
      begin n_err++; $display("FAIL sb_pop: got st=%b we=%b a=%0d want 1/1/3", core_stall, rf_we, rf_addrD); end
    @(negedge clk);
    #1;
    n_vec++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL sb_release: got stall=%b want 0", core_stall); end
`else
    n_vec++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL nosb_raw: got stall=%b want 0", core_stall); end
`endif
    @(negedge clk);
    rd_addrA = 0; iss_valid = 1; iss_addr = 0;
    @(negedge clk);
    iss_valid = 0;
    #1;
    n_vec++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL sb_x0: got stall=%b want 0", core_stall); end
  endtask

  task automatic test_reset_mid();
    logic exp_st;
    do_reset();
    @(negedge clk);
    p_we = 1; p_addr = 1; iss_valid = 1; iss_addr = 3; s_valid = 1; s_addr = 3; s_data = 32'hA;
    @(negedge clk);
    iss_valid = 0; s_addr = 4; s_data = 32'hB;
    @(negedge clk);
    s_addr = 5; s_data = 32'hC;
    @(negedge clk);
    s_valid = 0; rd_addrA = 3;
    #1;
`ifdef RF_WB_SCOREBOARD_EN
    exp_st = 1;
`else
    exp_st = 0;
`endif
    n_vec++; if (fifo_cnt !== 3'd3)     begin n_err++; $display("FAIL mid_cnt: got %0d want 3", fifo_cnt); end
    n_vec++; if (core_stall !== exp_st) begin n_err++; $display("FAIL mid_busy: got %b want %b", core_stall, exp_st); end
    #1 rst_n = 0;
    #1;
    n_vec++; if (fifo_cnt !== 3'd0 || rf_we !== 1'b0 || core_stall !== 1'b0)
      begin n_err++; $display("FAIL mid_reset: got cnt=%0d we=%b st=%b want 0/0/0", fifo_cnt, rf_we, core_stall); end
    @(negedge clk);
    rst_n = 1; p_we = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_vec++; if (rf_we !== 1'b0 || core_stall !== 1'b0 || fifo_cnt !== 3'd0)
        begin n_err++; $display("FAIL mid_stale: got we=%b st=%b cnt=%0d want 0/0/0", rf_we, core_stall, fifo_cnt); end
    end
  endtask

  task automatic test_random();
    exp_t          e;
    bit            p_hold, s_hold;
    logic [AW-1:0] pend[$];
    logic [AW-1:0] a;
    logic [2:0]    ecnt;
    do_reset();
    p_hold = 0; s_hold = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!p_hold) begin
        p_we = ($urandom_range(0, 9) < 7); p_addr = AW'($urandom_range(0, 31)); p_data = $urandom;
        rd_addrA = AW'($urandom_range(0, 31)); rd_addrB = AW'($urandom_range(0, 31));
      end
      if (!s_hold) begin
        s_valid = ($urandom_range(0, 9) < 4);
        if (s_valid && pend.size() != 0 && $urandom_range(0, 1) == 1) s_addr = pend.pop_front();
        else s_addr = AW'($urandom_range(0, 31));
        s_data = $urandom;
      end
      a = AW'($urandom_range(0, 31));
      iss_addr = a; iss_valid = ($urandom_range(0, 9) < 2) && !m_busy[a];
      #1;
      e = model_eval();
      ecnt = 3'(m_q.size());
      n_vec++;
      if (rf_we !== e.we || (e.we && (rf_addrD !== e.addr || rf_dataD !== e.data)) ||
          core_stall !== e.stall || s_ready !== e.sready || fifo_cnt !== ecnt) begin
        n_err++;
        $display("FAIL random cyc %0d: got we=%b a=%0d d=%h st=%b rdy=%b cnt=%0d want we=%b a=%0d d=%h st=%b rdy=%b cnt=%0d",
                 c, rf_we, rf_addrD, rf_dataD, core_stall, s_ready, fifo_cnt, e.we, e.addr, e.data, e.stall, e.sready, ecnt);
      end
      p_hold = e.stall;
      s_hold = s_valid && !e.push;
      if (iss_valid && !e.stall && iss_addr != 0) pend.push_back(iss_addr);
    end
  endtask

  initial begin
    test_reset();
    test_primary();
    test_drain();
    test_force();
    test_full();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
